// File: rtl/lambda_mem_arb.sv
// lambda_mem_arb: shares one sync-read RAM among fetch, data and host, with boot/run/halt sequencing
module lambda_mem_arb #(
    parameter int AW     = 13,
    parameter int DW     = 16,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    input  logic          host_done,
    input  logic          host_halt,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [1:0]    state
);
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

    state_t     r_state, w_next;
    logic [3:0] r_starve, w_starve_next;
    logic       r_if_rv, r_d_rv, r_h_rv;
    logic       w_run, w_promote;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state  <= BOOT;
            r_starve <= '0;
            r_if_rv  <= 1'b0;
            r_d_rv   <= 1'b0;
            r_h_rv   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_starve <= w_starve_next;
            r_if_rv  <= if_gnt;
            r_d_rv   <= d_gnt && !d_we;
            r_h_rv   <= h_gnt && !h_we;
        end

    always_comb begin
        w_next = BOOT;
        case (r_state)
            BOOT:    w_next = host_done ? RUN : BOOT;
            RUN:     w_next = host_halt ? HALT : RUN;
            HALT:    w_next = host_halt ? HALT : RUN;
            default: w_next = BOOT;
        endcase
    end

    // A fetch denied STARVE times in a row jumps ahead of host and data
    assign w_run     = r_state == RUN;
    assign w_promote = w_run && if_req && r_starve == 4'(STARVE);
    assign h_gnt     = !reset && h_req && !w_promote;
    assign d_gnt     = !reset && w_run && d_req && !h_req && !w_promote;
    assign if_gnt    = !reset && w_run && if_req && (w_promote || !(h_req || d_req));

    assign w_starve_next = (w_run && if_req && !if_gnt)
                         ? (r_starve == 4'(STARVE) ? r_starve : r_starve + 4'd1) : 4'd0;

    assign ram_en    = if_gnt || d_gnt || h_gnt;
    assign ram_we    = (d_gnt && d_we) || (h_gnt && h_we);
    assign ram_addr  = h_gnt ? h_addr : d_gnt ? d_addr : if_addr;
    assign ram_wdata = h_gnt ? h_wdata : d_wdata;

    assign if_rvalid = r_if_rv;
    assign d_rvalid  = r_d_rv;
    assign h_rvalid  = r_h_rv;
    assign rdata     = ram_rdata;
    assign state     = r_state;
endmodule

// File: tb/tb_lambda_mem_arb.sv
// tb_lambda_mem_arb: directed plan plus random traffic; a per-cycle rule model predicts grants
// and a scoreboard of expected read returns is drained by an independent monitor.
module tb_lambda_mem_arb;
    localparam int AW = 13, DW = 16, STARVE = 4;

    logic clk = 0, reset = 1;
    logic if_req = 0, d_req = 0, d_we = 0, h_req = 0, h_we = 0, host_done = 0, host_halt = 0;
    logic [AW-1:0] if_addr = 0, d_addr = 0, h_addr = 0;
    logic [DW-1:0] d_wdata = 0, h_wdata = 0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid, ram_en, ram_we;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [1:0] state;

    lambda_mem_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .host_done(host_done), .host_halt(host_halt), .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .state(state)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [2**AW];
    always @(posedge clk)
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end

    int vectors = 0, errs = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct { int due; int who; logic [DW-1:0] data; } exp_t;
    exp_t sbq[$];
    logic [DW-1:0] shadow [int];
    int m_state = 0, m_starve = 0;

    // Rule model: 1 = fetch, 2 = data, 3 = host
    always @(negedge clk) begin : model
        int win;
        logic core, promote, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        if (reset) begin
            m_state = 0;
            m_starve = 0;
            sbq.delete();
            chk("reset_gnt", {if_gnt, d_gnt, h_gnt, ram_en, ram_we}, 0);
        end else begin
            core = m_state == 1;
            promote = core && if_req && m_starve == STARVE;
            win = promote ? 1 : h_req ? 3 : (core && d_req) ? 2 : (core && if_req) ? 1 : 0;
            chk("state", state, m_state);
            chk("gnt", {if_gnt, d_gnt, h_gnt}, win == 1 ? 4 : win == 2 ? 2 : win == 3 ? 1 : 0);
            chk("ram_en", ram_en, win != 0);
            we = win == 2 ? d_we : win == 3 ? h_we : 1'b0;
            a  = win == 1 ? if_addr : win == 2 ? d_addr : h_addr;
            wd = win == 2 ? d_wdata : h_wdata;
            chk("ram_we", ram_we, we);
            if (win != 0) begin
                chk("ram_addr", ram_addr, a);
                if (we) begin
                    chk("ram_wdata", ram_wdata, wd);
                    shadow[a] = wd;
                end else sbq.push_back('{cyc + 1, win, shadow[a]});
            end
            m_starve = (core && if_req && win != 1) ? (m_starve < STARVE ? m_starve + 1 : STARVE) : 0;
            if (m_state == 0 && host_done) m_state = 1;
            else if (m_state == 1 && host_halt) m_state = 2;
            else if (m_state == 2 && !host_halt) m_state = 1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) chk("reset_rvalid", {if_rvalid, d_rvalid, h_rvalid}, 0);
        else if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rv_owner", {if_rvalid, d_rvalid, h_rvalid}, e.who == 1 ? 4 : e.who == 2 ? 2 : 1);
            chk("rv_data", rdata, e.data);
        end else chk("no_rvalid", {if_rvalid, d_rvalid, h_rvalid}, 0);
    end

    task automatic step(output logic gi, output logic gd, output logic gh);
        @(negedge clk);
        gi = if_gnt; gd = d_gnt; gh = h_gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input int who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic gi, gd, gh;
        bit got = 0;
        if (who == 1) begin if_req = 1; if_addr = a; end
        else if (who == 2) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; end
        else begin h_req = 1; h_we = we; h_addr = a; h_wdata = wd; end
        for (int k = 0; k < 40 && !got; k++) begin
            step(gi, gd, gh);
            got = who == 1 ? gi : who == 2 ? gd : gh;
        end
        chk("acc_granted", got, 1);
        if (who == 1) if_req = 0; else if (who == 2) d_req = 0; else h_req = 0;
    endtask

    function automatic logic [AW-1:0] pick();
        int r = $urandom_range(0, 18);
        return r < 16 ? 13'(32 + r) : r == 16 ? 13'h10 : r == 17 ? 13'h11 : 13'h100;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic gi, gd, gh;
        logic [DW-1:0] burst [3];
        bit got;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        reset = 0;

        // Boot: host loads while fetch waits
        if_req = 1; if_addr = 13'h10;
        acc(3, 1, 13'h10, 16'h1234);
        acc(3, 1, 13'h11, 16'h5678);
        acc(3, 1, 13'h100, 16'h0);
        for (int i = 0; i < 16; i++) acc(3, 1, 13'(32 + i), 16'($urandom));
        if_req = 1;
        host_done = 1;
        step(gi, gd, gh);
        host_done = 0;
        chk("boot_to_run", state, 1);
        acc(1, 0, 13'h10, 0);
        chk("boot_fetch_rv", if_rvalid, 1);
        chk("boot_fetch_data", rdata, 16'h1234);

        // Priority
        h_req = 1; h_we = 0; h_addr = 13'h20;
        d_req = 1; d_we = 0; d_addr = 13'h21;
        if_req = 1; if_addr = 13'h22;
        step(gi, gd, gh); chk("prio_host", {gi, gd, gh}, 3'b001); h_req = 0;
        step(gi, gd, gh); chk("prio_data", {gi, gd, gh}, 3'b010); d_req = 0;
        step(gi, gd, gh); chk("prio_fetch", {gi, gd, gh}, 3'b100); if_req = 0;

        // Starvation
        d_req = 1; d_we = 0; if_req = 1; if_addr = 13'h23;
        for (int k = 1; k <= 6; k++) begin
            d_addr = 13'(32 + k);
            step(gi, gd, gh);
            chk("starve_cycle", {gi, gd}, k == 5 ? 2'b10 : 2'b01);
        end
        d_req = 0; if_req = 0;

        // Halt during a data read stream
        d_req = 1; d_we = 0; d_addr = 13'h20;
        step(gi, gd, gh); chk("halt_pre_gnt", gd, 1);
        d_addr = 13'h21; host_halt = 1;
        step(gi, gd, gh); chk("halt_edge_gnt", gd, 1);
        chk("halt_state", state, 2);
        chk("halt_inflight_rv", d_rvalid, 1);
        d_addr = 13'h22;
        repeat (3) begin step(gi, gd, gh); chk("halt_no_core", gd, 0); end
        acc(3, 0, 13'h11, 0);
        chk("halt_host_rv", h_rvalid, 1);
        chk("halt_host_data", rdata, 16'h5678);
        host_halt = 0;
        got = 0;
        for (int k = 0; k < 5 && !got; k++) begin step(gi, gd, gh); got = gd; end
        chk("unhalt_core_gnt", got, 1);
        chk("unhalt_state", state, 1);
        d_req = 0;

        // Write then read-back on the data port
        d_req = 1; d_we = 1; d_addr = 13'h100; d_wdata = 16'hBEEF;
        step(gi, gd, gh); chk("wr_gnt", gd, 1);
        d_we = 0;
        chk("wr_no_rv", d_rvalid, 0);
        step(gi, gd, gh); chk("rd_gnt", gd, 1);
        d_req = 0;
        chk("rd_rv", d_rvalid, 1);
        chk("rd_data", rdata, 16'hBEEF);

        // Async reset in the middle of a host burst
        for (int i = 0; i < 3; i++) begin
            burst[i] = 16'($urandom);
            acc(3, 1, 13'(64 + i), burst[i]);
        end
        h_req = 1; h_we = 0; h_addr = 13'h40;
        step(gi, gd, gh); chk("arst_pre_read", gh, 1);
        h_we = 1; h_addr = 13'h43; h_wdata = 16'hDEAD;
        #1 reset = 1;
        h_req = 0;
        #1;
        chk("arst_gnt", {if_gnt, d_gnt, h_gnt, ram_en, ram_we}, 0);
        chk("arst_rv", {if_rvalid, d_rvalid, h_rvalid}, 0);
        chk("arst_state", state, 0);
        @(posedge clk);
        #2 reset = 0;
        for (int i = 0; i < 3; i++) begin
            acc(3, 0, 13'(64 + i), 0);
            chk("arst_readback", rdata, burst[i]);
        end
        host_done = 1;
        step(gi, gd, gh);
        host_done = 0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if (!if_req && $urandom_range(0, 3) != 0) begin if_req = 1; if_addr = pick(); end
            if (!d_req && $urandom_range(0, 1) != 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = pick(); d_wdata = 16'($urandom);
            end
            if (!h_req && $urandom_range(0, 3) == 0) begin
                h_req = 1; h_we = 1'($urandom_range(0, 1)); h_addr = pick(); h_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 63) == 0) host_halt = !host_halt;
            step(gi, gd, gh);
            if (gi) if_req = 0;
            if (gd) d_req = 0;
            if (gh) h_req = 0;
        end
        if_req = 0; d_req = 0; h_req = 0; host_halt = 0;
        repeat (3) step(gi, gd, gh);
        chk("sb_drain", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
